// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I integer subset with one Avalon-MM style master port.
// Instruction fetch and data access share the port; only one transfer is
// outstanding at a time. The core halts when control transfers to address 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | read at PC, latch IR when waitrequest drops
// EXEC    | decode IR, ALU, write back, advance PC/next_PC (or go to MEM)
// MEM     | LW/SW data transfer at rs+sext(imm), retire when accepted
// HALTED  | jumped to 0; no bus activity until reset
module mips_cpu_bus (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_MEM    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] gpr_q [32];

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] sext_imm, zext_imm;
  logic [31:0] rs_val, rt_val;
  logic [31:0] mem_addr;

  logic [31:0] alu_res;
  logic [4:0]  alu_dst;
  logic        alu_we;
  logic [31:0] npc_next;
  logic        is_mem, is_lw;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'h0000, ir_q[15:0]};
  // $0 is cleared at reset and never written, so it always reads 0
  assign rs_val   = gpr_q[rs];
  assign rt_val   = gpr_q[rt];
  assign mem_addr = (rs_val + sext_imm) & 32'hFFFF_FFFC;

  assign register_v0 = gpr_q[2];
  assign writedata   = rt_val;
  assign byteenable  = 4'b1111;

  // Decode and execute: ALU result, destination and the following next_PC
  always_comb begin
    alu_res  = 32'h0;
    alu_dst  = rd;
    alu_we   = 1'b0;
    npc_next = npc_q + 32'd4;
    is_mem   = 1'b0;
    is_lw    = 1'b0;
    unique case (opcode)
      OP_SPECIAL: begin
        unique case (funct)
          F_SLL:  begin alu_res = rt_val << shamt; alu_we = 1'b1; end
          F_SRL:  begin alu_res = rt_val >> shamt; alu_we = 1'b1; end
          F_SRA:  begin alu_res = 32'($signed(rt_val) >>> shamt); alu_we = 1'b1; end
          F_JR:   npc_next = rs_val;
          F_JALR: begin
            npc_next = rs_val;
            alu_res  = pc_q + 32'd8;
            alu_we   = 1'b1;
          end
          F_ADDU: begin alu_res = rs_val + rt_val; alu_we = 1'b1; end
          F_SUBU: begin alu_res = rs_val - rt_val; alu_we = 1'b1; end
          F_AND:  begin alu_res = rs_val & rt_val; alu_we = 1'b1; end
          F_OR:   begin alu_res = rs_val | rt_val; alu_we = 1'b1; end
          F_XOR:  begin alu_res = rs_val ^ rt_val; alu_we = 1'b1; end
          F_SLT:  begin
            alu_res = {31'h0, $signed(rs_val) < $signed(rt_val)};
            alu_we  = 1'b1;
          end
          F_SLTU: begin alu_res = {31'h0, rs_val < rt_val}; alu_we = 1'b1; end
          default: ;
        endcase
      end
      OP_J:   npc_next = {npc_q[31:28], ir_q[25:0], 2'b00};
      OP_JAL: begin
        npc_next = {npc_q[31:28], ir_q[25:0], 2'b00};
        alu_res  = pc_q + 32'd8;
        alu_dst  = 5'd31;
        alu_we   = 1'b1;
      end
      OP_BEQ: if (rs_val == rt_val) npc_next = npc_q + (sext_imm << 2);
      OP_BNE: if (rs_val != rt_val) npc_next = npc_q + (sext_imm << 2);
      OP_ADDIU: begin alu_res = rs_val + sext_imm; alu_dst = rt; alu_we = 1'b1; end
      OP_SLTI: begin
        alu_res = {31'h0, $signed(rs_val) < $signed(sext_imm)};
        alu_dst = rt;
        alu_we  = 1'b1;
      end
      OP_SLTIU: begin
        alu_res = {31'h0, rs_val < sext_imm};
        alu_dst = rt;
        alu_we  = 1'b1;
      end
      OP_ANDI: begin alu_res = rs_val & zext_imm; alu_dst = rt; alu_we = 1'b1; end
      OP_ORI:  begin alu_res = rs_val | zext_imm; alu_dst = rt; alu_we = 1'b1; end
      OP_XORI: begin alu_res = rs_val ^ zext_imm; alu_dst = rt; alu_we = 1'b1; end
      OP_LUI:  begin alu_res = {ir_q[15:0], 16'h0000}; alu_dst = rt; alu_we = 1'b1; end
      OP_LW:   begin is_mem = 1'b1; is_lw = 1'b1; alu_dst = rt; end
      OP_SW:   is_mem = 1'b1;
      default: ;
    endcase
  end

  // Next-state, bus outputs and register write-back
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_waddr = alu_dst;
    rf_wdata = alu_res;
    read     = 1'b0;
    write    = 1'b0;
    address  = pc_q;
    active   = (state_q != S_HALTED);
    unique case (state_q)
      S_FETCH: begin
        read = 1'b1;
        if (!waitrequest) begin
          ir_d    = readdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          state_d = S_MEM;
        end else begin
          rf_we   = alu_we;
          pc_d    = npc_q;
          npc_d   = npc_next;
          state_d = (npc_q == 32'h0) ? S_HALTED : S_FETCH;
        end
      end
      S_MEM: begin
        address = mem_addr;
        read    = is_lw;
        write   = !is_lw;
        if (!waitrequest) begin
          rf_we    = is_lw;
          rf_wdata = readdata;
          pc_d     = npc_q;
          npc_d    = npc_next;
          state_d  = (npc_q == 32'h0) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: ;
      default: state_d = S_HALTED;
    endcase
    // reset must silence the bus in the same cycle it is asserted
    if (reset) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  // Control state, PC pair and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VECTOR;
      npc_q   <= RESET_VECTOR + 32'd4;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
    end
  end

  // General-purpose register file; writes to $0 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      gpr_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Directed program bench for mips_cpu_bus: a small ROM at the reset vector
// and one data word, with bus cycles checked at every falling edge.
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  logic [31:0] rom [0:63];
  int tests = 0;
  int fails = 0;

  mips_cpu_bus dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .register_v0(register_v0),
    .address    (address),
    .write      (write),
    .read       (read),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    readdata = 32'h0;
    if (address[31:8] == 24'hBFC000) readdata = rom[address[7:2]];
    else if (address == 32'h0000_1004) readdata = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // From a FETCH cycle: one EXEC cycle, then the next FETCH cycle
  task automatic alu_step(input string tag, input logic [31:0] next_pc, input logic [31:0] v0);
    tick();
    chk({tag, "_exec_read"}, {31'h0, read}, 32'h0);
    tick();
    chk({tag, "_fetch_addr"}, address, next_pc);
    chk({tag, "_fetch_read"}, {31'h0, read}, 32'h1);
    chk({tag, "_v0"}, register_v0, v0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[6'h00] = 32'h3C021234; // LUI   $2,0x1234
    rom[6'h01] = 32'h3C0206C2; // LUI   $2,0x06C2
    rom[6'h02] = 32'h24031000; // ADDIU $3,$0,0x1000
    rom[6'h03] = 32'h8C620004; // LW    $2,4($3)
    rom[6'h04] = 32'h3C02CAFE; // LUI   $2,0xCAFE
    rom[6'h05] = 32'h3442F00D; // ORI   $2,$2,0xF00D
    rom[6'h06] = 32'hAC62FFFC; // SW    $2,-4($3)
    rom[6'h07] = 32'h2405FFFD; // ADDIU $5,$0,-3
    rom[6'h08] = 32'h00A3102A; // SLT   $2,$5,$3
    rom[6'h09] = 32'h00A3102B; // SLTU  $2,$5,$3
    rom[6'h0A] = 32'h00051043; // SRA   $2,$5,1
    rom[6'h0B] = 32'h00651023; // SUBU  $2,$3,$5
    rom[6'h0C] = 32'h38A200FF; // XORI  $2,$5,0xFF
    rom[6'h0D] = 32'h10000002; // BEQ   $0,$0,+2
    rom[6'h0E] = 32'h24020007; // ADDIU $2,$0,7 (delay slot)
    rom[6'h0F] = 32'h24020063; // skipped
    rom[6'h10] = 32'h0FF00014; // JAL   0xBFC00050
    rom[6'h11] = 32'h03E01021; // ADDU  $2,$31,$0 (delay slot)
    rom[6'h12] = 32'h24020063; // skipped
    rom[6'h13] = 32'h24020063; // skipped
    rom[6'h14] = 32'h00800008; // JR    $4 ($4 = 0)
    rom[6'h15] = 32'h24420001; // ADDIU $2,$2,1 (delay slot)

    waitrequest = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    tick();
    chk("rst_read", {31'h0, read}, 32'h0);
    chk("rst_write", {31'h0, write}, 32'h0);
    chk("rst_v0", register_v0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    tick();
    chk("boot_active", {31'h0, active}, 32'h1);
    chk("boot_addr", address, 32'hBFC0_0000);
    chk("boot_read", {31'h0, read}, 32'h1);
    chk("boot_write", {31'h0, write}, 32'h0);
    chk("boot_be", {28'h0, byteenable}, 32'hF);

    alu_step("lui1", 32'hBFC0_0004, 32'h1234_0000);
    alu_step("lui2", 32'hBFC0_0008, 32'h06C2_0000);
    alu_step("addiu_base", 32'hBFC0_000C, 32'h06C2_0000);

    tick();
    chk("lw_exec_read", {31'h0, read}, 32'h0);
    tick();
    chk("lw_mem_read", {31'h0, read}, 32'h1);
    chk("lw_mem_write", {31'h0, write}, 32'h0);
    chk("lw_mem_addr", address, 32'h0000_1004);
    tick();
    chk("lw_fetch_addr", address, 32'hBFC0_0010);
    chk("lw_v0", register_v0, 32'hDEAD_BEEF);

    alu_step("lui_cafe", 32'hBFC0_0014, 32'hCAFE_0000);
    alu_step("ori_f00d", 32'hBFC0_0018, 32'hCAFE_F00D);

    tick();
    waitrequest = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("sw_write", {31'h0, write}, 32'h1);
      chk("sw_read", {31'h0, read}, 32'h0);
      chk("sw_addr", address, 32'h0000_0FFC);
      chk("sw_wdata", writedata, 32'hCAFE_F00D);
      chk("sw_be", {28'h0, byteenable}, 32'hF);
    end
    waitrequest = 1'b0;
    tick();
    chk("sw_fetch_addr", address, 32'hBFC0_001C);
    chk("sw_fetch_read", {31'h0, read}, 32'h1);

    alu_step("addiu_neg", 32'hBFC0_0020, 32'hCAFE_F00D);
    alu_step("slt", 32'hBFC0_0024, 32'h0000_0001);
    alu_step("sltu", 32'hBFC0_0028, 32'h0000_0000);
    alu_step("sra", 32'hBFC0_002C, 32'hFFFF_FFFE);
    alu_step("subu", 32'hBFC0_0030, 32'h0000_1003);
    alu_step("xori", 32'hBFC0_0034, 32'hFFFF_FF02);
    alu_step("beq", 32'hBFC0_0038, 32'hFFFF_FF02);
    alu_step("beq_slot", 32'hBFC0_0040, 32'h0000_0007);
    alu_step("jal", 32'hBFC0_0044, 32'h0000_0007);
    alu_step("jal_slot", 32'hBFC0_0050, 32'hBFC0_0048);
    alu_step("jr", 32'hBFC0_0054, 32'hBFC0_0048);

    tick();
    chk("slot_exec_active", {31'h0, active}, 32'h1);
    tick();
    chk("halt_active", {31'h0, active}, 32'h0);
    chk("halt_read", {31'h0, read}, 32'h0);
    chk("halt_v0", register_v0, 32'hBFC0_0049);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("halt_hold_active", {31'h0, active}, 32'h0);
      chk("halt_hold_bus", {30'h0, read, write}, 32'h0);
      chk("halt_hold_v0", register_v0, 32'hBFC0_0049);
    end

    reset = 1'b1;
    tick();
    chk("rerst_active", {31'h0, active}, 32'h1);
    chk("rerst_read", {31'h0, read}, 32'h0);
    chk("rerst_v0", register_v0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("reboot_addr", address, 32'hBFC0_0000);
    chk("reboot_read", {31'h0, read}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus.md
Name: mips_cpu_bus

Overview:
- Multicycle, non-pipelined MIPS-I integer CPU subset with a single Avalon-MM style memory master port, shared by instruction fetch and data access.
- Top-level CPU block: it connects directly to the system memory/bus and exposes register $2 ($v0) for observation.
- Execution starts at the reset vector 0xBFC00000. The CPU halts when it jumps to address 0.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- active  output  1  high while the CPU is executing; low once halted.
- register_v0  output  32  current contents of GPR $2, combinational from the register file.
- address  output  32  bus byte address, always word aligned (bits [1:0] forced to 00).
- write  output  1  bus write request.
- read  output  1  bus read request.
- waitrequest  input  1  slave stall; a transfer completes on a rising edge where waitrequest=0.
- writedata  output  32  store data (rt).
- byteenable  output  4  byte lanes; always 4'b1111.
- readdata  input  32  read data; valid in the completing cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (rising edge with reset=1):
  - PC=0xBFC00000, next_PC=0xBFC00004, state=FETCH, active=1.
  - All 32 GPRs cleared to 0.
  - While reset=1, read=0 and write=0.
- States: FETCH, EXEC, MEM, HALTED.
- FETCH:
  - read=1, write=0, address=PC.
  - Hold all bus outputs stable until waitrequest=0.
  - At that edge: IR<=readdata, go to EXEC.
- EXEC:
  - No bus request (read=0, write=0).
  - Decode IR and compute the ALU result.
  - For non-memory instructions, at the edge:
    - write back the result;
    - PC<=next_PC;
    - next_PC<=branch/jump target if taken, else next_PC+4;
    - go to FETCH.
  - Exception: if the new PC would be 0x00000000, go to HALTED instead.
  - LW/SW go to MEM without updating PC.
- MEM:
  - address = rs + sign_extend(imm16), with [1:0] forced to 00.
  - LW: read=1. SW: write=1, writedata=rt.
  - When waitrequest=0: LW writes readdata to rt, PC/next_PC update as in EXEC, go to FETCH (or HALTED).
- HALTED:
  - active=0, read=0, write=0. Registers retain their values.
  - Only reset leaves HALTED.
- Instruction latency: 2 cycles for ALU/branch/jump, 3 cycles for LW/SW, plus any waitrequest stall cycles.
- Delay slot: the instruction following a branch/jump always executes.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
- Arithmetic and immediate rules:
  - ANDI/ORI/XORI zero-extend imm.
  - ADDIU/SLTI/SLTIU/LW/SW sign-extend imm.
  - LUI: rt = {imm16, 16'h0}.
  - All additions wrap modulo 2^32; no overflow traps.
- Branch and jump targets:
  - Branch target = (address of delay slot) + (sext(imm)<<2).
  - J/JAL target = {delay-slot PC[31:28], instr_index, 2'b00}.
  - JAL writes $31 = PC+8; JALR writes rd = PC+8.
- Register file:
  - Writes to $0 are discarded; $0 always reads 0.
  - register_v0 reflects a write to $2 immediately after the writing edge.
- Unsupported opcodes execute as NOP (PC advances normally).
- Reset asserted mid-transfer (any state) overrides everything: the next edge enters the reset state, and read/write drop in that same cycle.

Test Plan:
- Reset, then hold waitrequest=0 → at the first negedge after reset release: active=1, address=0xBFC00000, read=1, write=0, byteenable=1111.
- Fetch 0x3C021234 (LUI $2,0x1234) → register_v0=0x12340000 after the EXEC edge; the next fetch is at 0xBFC00004. Follow with 0x3C0206C2 → register_v0=0x06C20000.
- Build base 0x00001000 in $3, then LW $2,4($3) (0x8C620004) with memory[0x1004]=0xDEADBEEF → MEM cycle shows read=1, address=0x00001004; then register_v0=0xDEADBEEF.
- SW $2,-4($3) with $2=0xCAFEF00D → write=1, address=0x00000FFC, writedata=0xCAFEF00D, byteenable=1111. Hold waitrequest=1 for 3 cycles → outputs stay stable until release.
- BEQ $0,$0,+2 followed by ADDIU $2,$0,7 (delay slot) → register_v0=7, and the next fetch address is branch PC+12.
- $4=0, JR $4 followed by ADDIU $2,$2,1 → the delay slot executes (v0 increments by 1), then active=0, read=0, and v0 stays stable thereafter.
